gmii_rx_video: RTL

//  GMII receiver for the UDP/IPv4 video stream emitted by the gmii_tx block (YUV422 line packets).

---
 rtl/gmii_rx_video_if.sv | 24 ++
 rtl/gmii_rx_video.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_video_if.sv
// rtl/gmii_rx_video_if.sv - GMII receive pins and video FIFO write side
// master drives the PHY pins and FIFO status; slave is the receiver.
interface gmii_rx_video_if;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic        fifo_full;
  logic        pix_wr_en;
  logic [15:0] pix_data;
  logic [15:0] line_num;
  logic        sof;
  logic        frame_done;
  logic        frame_ok;

  modport master (
    output rx_dv, rx_er, rxd, fifo_full,
    input  pix_wr_en, pix_data, line_num, sof, frame_done, frame_ok
  );

  modport slave (
    input  rx_dv, rx_er, rxd, fifo_full,
    output pix_wr_en, pix_data, line_num, sof, frame_done, frame_ok
  );
endinterface

// File: rtl/gmii_rx_video.sv
// rtl/gmii_rx_video.sv - GMII receiver for UDP/IPv4 YUV422 line packets
// Filters Eth/IP/UDP headers, writes payload pairs to the video FIFO, checks FCS.
module gmii_rx_video #(
  parameter logic [47:0] my_mac      = 48'h002345678902,
  parameter logic [31:0] my_ip       = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [15:0] my_port     = 16'd12346,
  parameter logic [15:0] packet_size = 16'd1280
) (
  input  logic            rx_clk,
  input  logic            sys_rst_n,
  input  logic            id,
  gmii_rx_video_if.slave  vif
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PRE     = 3'd1;
  localparam logic [2:0] HDR     = 3'd2;
  localparam logic [2:0] RESOL   = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;
  localparam logic [2:0] FCS     = 3'd5;
  localparam logic [2:0] CHECK   = 3'd6;
  localparam logic [2:0] WAIT    = 3'd7;

  localparam logic [15:0] IP_LEN   = packet_size + 16'd30;
  localparam logic [15:0] UDP_LEN  = packet_size + 16'd10;
  localparam logic [11:0] LAST_PAY = 12'(packet_size + 16'd43);
  localparam logic [11:0] LAST_FCS = 12'(packet_size + 16'd47);
  // MSB-first register holding the bit-reversed reflected CRC, so the good-frame residue reads C704DD7B
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [2:0]  state_q, state_d;
  logic [11:0] b_q, b_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d, ovf_q, ovf_d, dv_q, dv_d;
  logic [7:0]  pair_hi_q, pair_hi_d, line_hi_q, line_hi_d;
  logic        pix_wr_en_q, pix_wr_en_d, sof_q, sof_d;
  logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [15:0] pix_data_q, pix_data_d, line_num_q, line_num_d;
  logic [7:0]  mac_lo, ip_lo, hdr_exp;
  logic        hdr_chk;

  assign mac_lo = my_mac[7:0] - {7'd0, id};
  assign ip_lo  = my_ip[7:0] - {7'd0, id};

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return c;
  endfunction

  always_comb begin
    hdr_exp = 8'h00;
    hdr_chk = 1'b1;
    case (b_q)
      12'd0:  hdr_exp = my_mac[47:40];
      12'd1:  hdr_exp = my_mac[39:32];
      12'd2:  hdr_exp = my_mac[31:24];
      12'd3:  hdr_exp = my_mac[23:16];
      12'd4:  hdr_exp = my_mac[15:8];
      12'd5:  hdr_exp = mac_lo;
      12'd12: hdr_exp = 8'h08;
      12'd13: hdr_exp = 8'h00;
      12'd14: hdr_exp = 8'h45;
      12'd16: hdr_exp = IP_LEN[15:8];
      12'd17: hdr_exp = IP_LEN[7:0];
      12'd23: hdr_exp = 8'h11;
      12'd30: hdr_exp = my_ip[31:24];
      12'd31: hdr_exp = my_ip[23:16];
      12'd32: hdr_exp = my_ip[15:8];
      12'd33: hdr_exp = ip_lo;
      12'd36: hdr_exp = my_port[15:8];
      12'd37: hdr_exp = my_port[7:0];
      12'd38: hdr_exp = UDP_LEN[15:8];
      12'd39: hdr_exp = UDP_LEN[7:0];
      default: hdr_chk = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    crc_d        = crc_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    dv_d         = vif.rx_dv;
    pair_hi_d    = pair_hi_q;
    line_hi_d    = line_hi_q;
    pix_wr_en_d  = 1'b0;
    pix_data_d   = pix_data_q;
    line_num_d   = line_num_q;
    sof_d        = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;

    if (vif.rx_dv && (state_q == HDR || state_q == RESOL || state_q == PAYLOAD || state_q == FCS)) begin
      crc_d = crc_step(crc_q, vif.rxd);
      b_d   = b_q + 12'd1;
      if (vif.rx_er) err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (vif.rx_dv && !dv_q) state_d = (vif.rxd == 8'h55) ? PRE : WAIT;
      end
      PRE: begin
        if (!vif.rx_dv) state_d = IDLE;
        else if (vif.rxd == 8'hD5) begin
          state_d = HDR;
          b_d     = 12'd0;
          crc_d   = 32'hFFFFFFFF;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (vif.rxd != 8'h55) state_d = WAIT;
      end
      HDR: begin
        if (!vif.rx_dv) state_d = IDLE;
        else if (hdr_chk && vif.rxd != hdr_exp) state_d = WAIT;
        else if (b_q == 12'd41) state_d = RESOL;
      end
      RESOL, PAYLOAD, FCS: begin
        // Once the header is accepted, a truncated frame is still reported as done/bad
        if (!vif.rx_dv) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else if (state_q == RESOL) begin
          if (b_q == 12'd42) line_hi_d = vif.rxd;
          else begin
            line_num_d = {line_hi_q, vif.rxd};
            sof_d      = 1'b1;
            state_d    = PAYLOAD;
          end
        end else if (state_q == PAYLOAD) begin
          if (!b_q[0]) pair_hi_d = vif.rxd;
          else begin
            pix_data_d = {pair_hi_q, vif.rxd};
            if (vif.fifo_full) ovf_d = 1'b1;
            else pix_wr_en_d = 1'b1;
          end
          if (b_q == LAST_PAY) state_d = FCS;
        end else if (b_q == LAST_FCS) state_d = CHECK;
      end
      CHECK: begin
        frame_done_d = 1'b1;
        frame_ok_d   = (crc_q == CRC_RESIDUE) && !err_q && !ovf_q;
        state_d      = vif.rx_dv ? WAIT : IDLE;
      end
      default: begin
        if (!vif.rx_dv) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      b_q          <= 12'd0;
      crc_q        <= 32'hFFFFFFFF;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      dv_q         <= 1'b0;
      pair_hi_q    <= 8'h00;
      line_hi_q    <= 8'h00;
      pix_wr_en_q  <= 1'b0;
      pix_data_q   <= 16'h0000;
      line_num_q   <= 16'h0000;
      sof_q        <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      crc_q        <= crc_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      dv_q         <= dv_d;
      pair_hi_q    <= pair_hi_d;
      line_hi_q    <= line_hi_d;
      pix_wr_en_q  <= pix_wr_en_d;
      pix_data_q   <= pix_data_d;
      line_num_q   <= line_num_d;
      sof_q        <= sof_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
    end
  end

  assign vif.pix_wr_en  = pix_wr_en_q;
  assign vif.pix_data   = pix_data_q;
  assign vif.line_num   = line_num_q;
  assign vif.sof        = sof_q;
  assign vif.frame_done = frame_done_q;
  assign vif.frame_ok   = frame_ok_q;
endmodule
